tt_vecld_resp_asm: RTL and testbench



---
 rtl/tt_briscv_pkg.sv | 48 ++++
 rtl/tt_vecld_byte_merge.sv | 43 ++++
 rtl/tt_vecld_resp_asm.sv | 177 +++++++++++++++++
 tb/tb_tt_vecld_resp_asm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_briscv_pkg.sv
// Shared types for the vector-load response assembler: beat/writeback records,
// assembler state encoding and the scalar load extension helper.
package tt_briscv_pkg;

  localparam int VECLD_VLEN     = 256;
  localparam int VECLD_DATA_W   = 128;
  localparam int VECLD_LQ_DEPTH = 8;
  localparam int VECLD_LQID_W   = $clog2(VECLD_LQ_DEPTH);
  localparam int VECLD_OFF_W    = $clog2(VECLD_VLEN / 8);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } vecld_asm_state_e;

  typedef struct packed {
    logic [VECLD_LQID_W-1:0]   lqid;
    logic                      vec;
    logic [2:0]                sz;
    logic [VECLD_DATA_W-1:0]   data;
    logic [VECLD_OFF_W-1:0]    byte_off;
    logic [VECLD_DATA_W/8-1:0] byte_mask;
    logic                      last;
    logic                      err;
  } vecld_resp_s;

  typedef struct packed {
    logic [VECLD_LQID_W-1:0]   lqid;
    logic                      vec;
    logic [VECLD_VLEN-1:0]     data;
    logic [VECLD_VLEN/8-1:0]   byte_mask;
    logic                      err;
  } vecld_wb_s;

  // Returns {err, data}; reserved size codes yield zero data with err set.
  function automatic logic [32:0] vecld_scalar_ext(input logic [2:0] sz, input logic [31:0] d);
    case (sz)
      3'd0:    return {1'b0, {24{d[7]}}, d[7:0]};
      3'd1:    return {1'b0, {16{d[15]}}, d[15:0]};
      3'd2:    return {1'b0, d};
      3'd4:    return {1'b0, 24'h0, d[7:0]};
      3'd5:    return {1'b0, 16'h0, d[15:0]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

endpackage

// File: rtl/tt_vecld_byte_merge.sv
// Places one response beat at its destination byte offset inside the VLEN
// buffer, honouring the beat byte mask; bytes landing past the end are dropped.
module tt_vecld_byte_merge
  import tt_briscv_pkg::*;
#(
  parameter int VLEN   = VECLD_VLEN,
  parameter int DATA_W = VECLD_DATA_W
) (
  input  logic [VLEN-1:0]           buf_data,
  input  logic [VLEN/8-1:0]         buf_mask,
  input  logic [DATA_W-1:0]         beat_data,
  input  logic [$clog2(VLEN/8)-1:0] byte_off,
  input  logic [DATA_W/8-1:0]       byte_mask,
  output logic [VLEN-1:0]           merged_data,
  output logic [VLEN/8-1:0]         merged_mask,
  output logic                      out_of_range
);

  localparam int OFF_W      = $clog2(VLEN / 8);
  localparam int BEAT_BYTES = DATA_W / 8;

  logic [OFF_W:0] dest;

  // The extra top bit of dest flags a destination beyond the buffer (no wrap).
  always_comb begin
    merged_data  = buf_data;
    merged_mask  = buf_mask;
    out_of_range = 1'b0;
    dest         = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (byte_mask[k]) begin
        dest = {1'b0, byte_off} + (OFF_W + 1)'(k);
        if (dest[OFF_W]) begin
          out_of_range = 1'b1;
        end else begin
          merged_data[{dest[OFF_W-1:0], 3'b000} +: 8] = beat_data[k*8 +: 8];
          merged_mask[dest[OFF_W-1:0]]               = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tt_vecld_resp_asm.sv
// Assembles in-order memory response beats into load writebacks (scalar
// extend or vector byte-merge). Optional TT_VECLD_RESP_LQID_CHK_EN checks lqid.
module tt_vecld_resp_asm
  import tt_briscv_pkg::*;
#(
  parameter int VLEN     = VECLD_VLEN,
  parameter int DATA_W   = VECLD_DATA_W,
  parameter int LQ_DEPTH = VECLD_LQ_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_resp_valid,
  output logic                        o_resp_ready,
  input  logic [$clog2(LQ_DEPTH)-1:0] i_resp_lqid,
  input  logic                        i_resp_vec,
  input  logic [2:0]                  i_resp_sz,
  input  logic [DATA_W-1:0]           i_resp_data,
  input  logic [$clog2(VLEN/8)-1:0]   i_resp_byte_off,
  input  logic [DATA_W/8-1:0]         i_resp_byte_mask,
  input  logic                        i_resp_last,
  input  logic                        i_resp_err,
  output logic                        o_wb_valid,
  input  logic                        i_wb_ready,
  output logic [$clog2(LQ_DEPTH)-1:0] o_wb_lqid,
  output logic                        o_wb_vec,
  output logic [VLEN-1:0]             o_wb_data,
  output logic [VLEN/8-1:0]           o_wb_byte_mask,
  output logic                        o_wb_err
);

  localparam int LQID_W = $clog2(LQ_DEPTH);

  vecld_asm_state_e   state;
  logic               wb_valid;
  logic [LQID_W-1:0]  wb_lqid;
  logic               wb_vec;
  logic [VLEN-1:0]    wb_data;
  logic [VLEN/8-1:0]  wb_mask;
  logic               wb_err;

  logic               accept;
  logic               lqid_mismatch;
  logic [VLEN-1:0]    base_data;
  logic [VLEN/8-1:0]  base_mask;
  logic [VLEN-1:0]    merge_data;
  logic [VLEN/8-1:0]  merge_mask;
  logic               merge_oob;
  logic [32:0]        scalar_ext;

  vecld_asm_state_e   start_state;
  logic               start_valid;
  logic [VLEN-1:0]    start_data;
  logic [VLEN/8-1:0]  start_mask;
  logic               start_err;

  assign o_resp_ready = (state != EMIT) | i_wb_ready;
  assign accept       = i_resp_valid & o_resp_ready;

  // A beat only merges onto the held buffer mid-assembly; otherwise it starts clean.
  assign base_data = (state == ACCUM) ? wb_data : '0;
  assign base_mask = (state == ACCUM) ? wb_mask : '0;

`ifdef TT_VECLD_RESP_LQID_CHK_EN
  assign lqid_mismatch = (i_resp_lqid != wb_lqid);
`else
  assign lqid_mismatch = 1'b0;
`endif

  tt_vecld_byte_merge #(
    .VLEN   (VLEN),
    .DATA_W (DATA_W)
  ) u_merge (
    .buf_data     (base_data),
    .buf_mask     (base_mask),
    .beat_data    (i_resp_data),
    .byte_off     (i_resp_byte_off),
    .byte_mask    (i_resp_byte_mask),
    .merged_data  (merge_data),
    .merged_mask  (merge_mask),
    .out_of_range (merge_oob)
  );

  assign scalar_ext = vecld_scalar_ext(i_resp_sz, i_resp_data[31:0]);

  always_comb begin
    start_state = EMIT;
    start_valid = 1'b1;
    start_data  = {{(VLEN-32){1'b0}}, scalar_ext[31:0]};
    start_mask  = {{(VLEN/8-4){1'b0}}, 4'hF};
    start_err   = i_resp_err | scalar_ext[32];
    if (i_resp_vec) begin
      start_state = i_resp_last ? EMIT : ACCUM;
      start_valid = i_resp_last;
      start_data  = merge_data;
      start_mask  = merge_mask;
      start_err   = i_resp_err | merge_oob;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
      wb_lqid  <= '0;
      wb_vec   <= 1'b0;
      wb_data  <= '0;
      wb_mask  <= '0;
      wb_err   <= 1'b0;
    end else if (i_flush) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
      wb_mask  <= '0;
      wb_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= start_state;
            wb_valid <= start_valid;
            wb_lqid  <= i_resp_lqid;
            wb_vec   <= i_resp_vec;
            wb_data  <= start_data;
            wb_mask  <= start_mask;
            wb_err   <= start_err;
          end
        end
        ACCUM: begin
          if (accept) begin
            // A stray scalar (or foreign lqid) beat closes the assembly with an error.
            if (!i_resp_vec || lqid_mismatch) begin
              state    <= EMIT;
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
            end else begin
              wb_data <= merge_data;
              wb_mask <= merge_mask;
              wb_err  <= wb_err | i_resp_err | merge_oob;
              if (i_resp_last) begin
                state    <= EMIT;
                wb_valid <= 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (i_wb_ready) begin
            if (accept) begin
              state    <= start_state;
              wb_valid <= start_valid;
              wb_lqid  <= i_resp_lqid;
              wb_vec   <= i_resp_vec;
              wb_data  <= start_data;
              wb_mask  <= start_mask;
              wb_err   <= start_err;
            end else begin
              state    <= IDLE;
              wb_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_valid     = wb_valid;
  assign o_wb_lqid      = wb_lqid;
  assign o_wb_vec       = wb_vec;
  assign o_wb_data      = wb_data;
  assign o_wb_byte_mask = wb_mask;
  assign o_wb_err       = wb_err;

endmodule

// File: tb/tb_tt_vecld_resp_asm.sv
// Directed self-checking bench for tt_vecld_resp_asm (default parameters);
// lqid expectations follow TT_VECLD_RESP_LQID_CHK_EN when it is defined.
module tb_tt_vecld_resp_asm;
  import tt_briscv_pkg::*;

  logic           i_clk = 1'b0;
  logic           i_reset_n = 1'b1;
  logic           i_flush = 1'b0;
  logic           i_resp_valid = 1'b0;
  logic           o_resp_ready;
  logic [2:0]     i_resp_lqid = '0;
  logic           i_resp_vec = 1'b0;
  logic [2:0]     i_resp_sz = '0;
  logic [127:0]   i_resp_data = '0;
  logic [4:0]     i_resp_byte_off = '0;
  logic [15:0]    i_resp_byte_mask = '0;
  logic           i_resp_last = 1'b0;
  logic           i_resp_err = 1'b0;
  logic           o_wb_valid;
  logic           i_wb_ready = 1'b1;
  logic [2:0]     o_wb_lqid;
  logic           o_wb_vec;
  logic [255:0]   o_wb_data;
  logic [31:0]    o_wb_byte_mask;
  logic           o_wb_err;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] PAT_A = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PAT_B = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] PAT_C = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PAT_D = 128'h0123456789abcdef8877665544332211;

  tt_vecld_resp_asm dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_flush          (i_flush),
    .i_resp_valid     (i_resp_valid),
    .o_resp_ready     (o_resp_ready),
    .i_resp_lqid      (i_resp_lqid),
    .i_resp_vec       (i_resp_vec),
    .i_resp_sz        (i_resp_sz),
    .i_resp_data      (i_resp_data),
    .i_resp_byte_off  (i_resp_byte_off),
    .i_resp_byte_mask (i_resp_byte_mask),
    .i_resp_last      (i_resp_last),
    .i_resp_err       (i_resp_err),
    .o_wb_valid       (o_wb_valid),
    .i_wb_ready       (i_wb_ready),
    .o_wb_lqid        (o_wb_lqid),
    .o_wb_vec         (o_wb_vec),
    .o_wb_data        (o_wb_data),
    .o_wb_byte_mask   (o_wb_byte_mask),
    .o_wb_err         (o_wb_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic vecld_resp_s mkBeat(input logic [2:0] lqid, input logic vec, input logic [2:0] sz,
                                         input logic [127:0] data, input logic [4:0] off,
                                         input logic [15:0] mask, input logic last, input logic err);
    vecld_resp_s b;
    b.lqid = lqid; b.vec = vec; b.sz = sz; b.data = data;
    b.byte_off = off; b.byte_mask = mask; b.last = last; b.err = err;
    return b;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic driveBeat(input vecld_resp_s b);
    i_resp_valid     = 1'b1;
    i_resp_lqid      = b.lqid;
    i_resp_vec       = b.vec;
    i_resp_sz        = b.sz;
    i_resp_data      = b.data;
    i_resp_byte_off  = b.byte_off;
    i_resp_byte_mask = b.byte_mask;
    i_resp_last      = b.last;
    i_resp_err       = b.err;
  endtask

  // Presents one beat for a single clock edge, then withdraws it.
  task automatic applyStimulus(input vecld_resp_s b);
    driveBeat(b);
    tick();
    i_resp_valid = 1'b0;
  endtask

  task automatic checkWb(input string tag, input logic [2:0] lqid, input logic vec,
                         input logic [255:0] data, input logic [31:0] mask, input logic err);
    checkOutput({tag, "_valid"}, o_wb_valid, 1'b1);
    checkOutput({tag, "_lqid"}, o_wb_lqid, lqid);
    checkOutput({tag, "_vec"}, o_wb_vec, vec);
    checkOutput({tag, "_data"}, o_wb_data, data);
    checkOutput({tag, "_mask"}, o_wb_byte_mask, mask);
    checkOutput({tag, "_err"}, o_wb_err, err);
  endtask

  task automatic scalarOp(input string tag, input logic [2:0] lqid, input logic [2:0] sz,
                          input logic [127:0] data, input logic err,
                          input logic [31:0] exp_data, input logic exp_err);
    applyStimulus(mkBeat(lqid, 1'b0, sz, data, 5'd0, 16'h0, 1'b0, err));
    checkWb(tag, lqid, 1'b0, {224'h0, exp_data}, 32'h0000000F, exp_err);
    tick();
    checkOutput({tag, "_drain"}, o_wb_valid, 1'b0);
  endtask

  initial begin
    #1 i_reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_ready", o_resp_ready, 1'b1);
    checkOutput("rst_valid", o_wb_valid, 1'b0);
    checkOutput("rst_data", o_wb_data, 256'h0);
    checkOutput("rst_mask", o_wb_byte_mask, 32'h0);
    checkOutput("rst_err", o_wb_err, 1'b0);
    i_reset_n = 1'b1;
    tick();

    scalarOp("lb", 3'd3, 3'd0, 128'h80, 1'b0, 32'hFFFFFF80, 1'b0);
    scalarOp("lhu", 3'd1, 3'd5, 128'h8001, 1'b0, 32'h00008001, 1'b0);
    scalarOp("lh", 3'd2, 3'd1, 128'h12348001, 1'b0, 32'hFFFF8001, 1'b0);
    scalarOp("lw", 3'd4, 3'd2, {96'hDEADBEEF_00000000_11111111, 32'hCAFEF00D}, 1'b0, 32'hCAFEF00D, 1'b0);
    scalarOp("lbu_err", 3'd5, 3'd4, 128'hAB12FF, 1'b1, 32'h000000FF, 1'b1);
    scalarOp("bad_sz", 3'd6, 3'd3, 128'h12345678, 1'b0, 32'h0, 1'b1);

    applyStimulus(mkBeat(3'd4, 1'b1, 3'd0, PAT_A, 5'd0, 16'hFFFF, 1'b0, 1'b0));
    checkOutput("vec2_mid_valid", o_wb_valid, 1'b0);
    applyStimulus(mkBeat(3'd4, 1'b1, 3'd0, PAT_B, 5'd16, 16'hFFFF, 1'b1, 1'b0));
    checkWb("vec2", 3'd4, 1'b1, {PAT_B, PAT_A}, 32'hFFFFFFFF, 1'b0);
    tick();

    applyStimulus(mkBeat(3'd0, 1'b1, 3'd0, PAT_C, 5'd24, 16'hFFFF, 1'b1, 1'b0));
    checkWb("vec_oob", 3'd0, 1'b1, {PAT_C[63:0], 192'h0}, 32'hFF000000, 1'b1);
    tick();

    i_wb_ready = 1'b0;
    applyStimulus(mkBeat(3'd6, 1'b0, 3'd2, 128'h11223344, 5'd0, 16'h0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", o_wb_valid, 1'b1);
      checkOutput("bp_data", o_wb_data, 256'h11223344);
      checkOutput("bp_ready", o_resp_ready, 1'b0);
      tick();
    end
    i_wb_ready = 1'b1;
    driveBeat(mkBeat(3'd7, 1'b0, 3'd0, 128'h7F, 5'd0, 16'h0, 1'b0, 1'b0));
    #1;
    checkOutput("b2b_ready", o_resp_ready, 1'b1);
    tick();
    i_resp_valid = 1'b0;
    checkWb("b2b", 3'd7, 1'b0, 256'h7F, 32'h0000000F, 1'b0);
    tick();

    applyStimulus(mkBeat(3'd1, 1'b1, 3'd0, PAT_A, 5'd0, 16'hFFFF, 1'b0, 1'b0));
    i_flush = 1'b1;
    applyStimulus(mkBeat(3'd3, 1'b0, 3'd2, 128'h55, 5'd0, 16'h0, 1'b0, 1'b0));
    i_flush = 1'b0;
    checkOutput("flush_valid", o_wb_valid, 1'b0);
    checkOutput("flush_mask", o_wb_byte_mask, 32'h0);
    tick();
    checkOutput("flush_drop", o_wb_valid, 1'b0);
    applyStimulus(mkBeat(3'd2, 1'b1, 3'd0, PAT_D, 5'd8, 16'h00FF, 1'b1, 1'b0));
    checkWb("post_flush", 3'd2, 1'b1, {128'h0, PAT_D[63:0], 64'h0}, 32'h0000FF00, 1'b0);
    tick();

    applyStimulus(mkBeat(3'd5, 1'b1, 3'd0, 128'hAABBCCDD, 5'd0, 16'h000F, 1'b0, 1'b0));
    applyStimulus(mkBeat(3'd5, 1'b0, 3'd2, 128'h99, 5'd0, 16'h0, 1'b0, 1'b0));
    checkWb("stray_scalar", 3'd5, 1'b1, 256'hAABBCCDD, 32'h0000000F, 1'b1);
    tick();

    applyStimulus(mkBeat(3'd2, 1'b1, 3'd0, PAT_A, 5'd0, 16'hFFFF, 1'b0, 1'b0));
    applyStimulus(mkBeat(3'd5, 1'b1, 3'd0, PAT_B, 5'd16, 16'hFFFF, 1'b1, 1'b0));
`ifdef TT_VECLD_RESP_LQID_CHK_EN
    checkWb("lqid", 3'd2, 1'b1, {128'h0, PAT_A}, 32'h0000FFFF, 1'b1);
`else
    checkWb("lqid", 3'd2, 1'b1, {PAT_B, PAT_A}, 32'hFFFFFFFF, 1'b0);
`endif
    tick();

    applyStimulus(mkBeat(3'd1, 1'b1, 3'd0, PAT_A, 5'd4, 16'h00FF, 1'b0, 1'b1));
    checkOutput("pre_areset_mask", o_wb_byte_mask, 32'h00000FF0);
    i_reset_n = 1'b0;
    #2;
    checkOutput("areset_mask", o_wb_byte_mask, 32'h0);
    checkOutput("areset_data", o_wb_data, 256'h0);
    checkOutput("areset_err", o_wb_err, 1'b0);
    checkOutput("areset_ready", o_resp_ready, 1'b1);
    i_reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
